pc_sequencer: RTL

- Owns the program counter and drives the PC select mux: generates `sel_pc`, takes the mux result `output_sel_pc` back in, and registers it as the new PC.
- Sequences each instruction through fetch, execute and PC update with a handshake to instruction memory and to the execute control.
- Sits between the control unit, the PC select mux and the instruction memory port.
- Also flags misaligned PCs and counts retired instructions.

---
 rtl/pc_sequencer_if.sv | 58 +++++
 rtl/pc_sequencer.sv | 106 ++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and its neighbours: the control unit, the PC select
// mux and the instruction memory port.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  // From the PC select mux
  logic [WIDTH-1:0] output_sel_pc;
  // From instruction memory
  logic             fetch_ack;
  // From the control unit
  logic             instr_done;
  logic             branch;
  logic             zero;
  logic             jump;
  logic             jump_reg;
  logic             stall;
  // Driven by the sequencer
  logic [WIDTH-1:0] pc;
  logic [1:0]       sel_pc;
  logic             branch_taken;
  logic             fetch_req;
  logic             pc_error;
  logic [31:0]      retired;

  modport master (
    input  output_sel_pc,
    input  fetch_ack,
    input  instr_done,
    input  branch,
    input  zero,
    input  jump,
    input  jump_reg,
    input  stall,
    output pc,
    output sel_pc,
    output branch_taken,
    output fetch_req,
    output pc_error,
    output retired
  );

  modport slave (
    output output_sel_pc,
    output fetch_ack,
    output instr_done,
    output branch,
    output zero,
    output jump,
    output jump_reg,
    output stall,
    input  pc,
    input  sel_pc,
    input  branch_taken,
    input  fetch_req,
    input  pc_error,
    input  retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: steps each instruction through fetch, execute and PC update, drives
// the PC select mux, traps misaligned targets and counts retired instructions.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StUpdate,
    StError
  } state_e;

  localparam logic [1:0] SelAlu  = 2'd0;
  localparam logic [1:0] SelReg  = 2'd1;
  localparam logic [1:0] SelJump = 2'd2;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [1:0]       sel_pc_q;
  logic             branch_taken_q;
  logic             pc_error_q;
  logic [31:0]      retired_q;
  logic             target_aligned;

  assign target_aligned = (bus.output_sel_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pc_q           <= RESET_PC;
      sel_pc_q       <= SelAlu;
      branch_taken_q <= 1'b0;
      pc_error_q     <= 1'b0;
      retired_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StFetch;
        end

        StFetch: begin
          if (bus.fetch_ack) begin
            state_q <= StExec;
          end
        end

        // Mux select is latched here so it stays stable for the whole UPDATE phase.
        StExec: begin
          if (bus.instr_done) begin
            if (bus.jump_reg) begin
              sel_pc_q       <= SelReg;
              branch_taken_q <= 1'b0;
            end else if (bus.jump) begin
              sel_pc_q       <= SelJump;
              branch_taken_q <= 1'b0;
            end else begin
              sel_pc_q       <= SelAlu;
              branch_taken_q <= bus.branch & bus.zero;
            end
            state_q <= StUpdate;
          end
        end

        StUpdate: begin
          if (!bus.stall) begin
            if (target_aligned) begin
              pc_q           <= bus.output_sel_pc;
              retired_q      <= retired_q + 32'd1;
              sel_pc_q       <= SelAlu;
              branch_taken_q <= 1'b0;
              state_q        <= StFetch;
            end else begin
              pc_error_q <= 1'b1;
              state_q    <= StError;
            end
          end
        end

        // Only reset leaves this state.
        StError: begin
          pc_error_q <= 1'b1;
          state_q    <= StError;
        end

        default: begin
          state_q <= StError;
        end
      endcase
    end
  end

  assign bus.pc           = pc_q;
  assign bus.sel_pc       = sel_pc_q;
  assign bus.branch_taken = branch_taken_q;
  assign bus.fetch_req    = (state_q == StFetch);
  assign bus.pc_error     = pc_error_q;
  assign bus.retired      = retired_q;

endmodule
